// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: owns the board RAM while the game clears lines. On start
// it scans rows bottom-up, drops full rows, compacts kept rows downward and
// zero-fills the top, then pulses done with the number of lines removed.
// Ports: CLOCK_50, resetn (sync, active-low); start/busy/done/lines_cleared
// to the game FSM; mem_raddr/mem_rdata (1-cycle sync read) and
// mem_we/mem_waddr/mem_wdata to board RAM; score (16-bit).
// Optional macro LINE_CLEAR_SCORE_EN: accumulate a saturating score on done;
// when undefined, score is tied to zero.
module line_clear_ctrl #(
    parameter int ROWS  = 20,
    parameter int COLS  = 10,
    parameter int ROW_W = 5
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [ROW_W-1:0] lines_cleared,
    output logic [ROW_W-1:0] mem_raddr,
    input  logic [COLS-1:0]  mem_rdata,
    output logic             mem_we,
    output logic [ROW_W-1:0] mem_waddr,
    output logic [COLS-1:0]  mem_wdata,
    output logic [15:0]      score
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_EV,
        S_FILL,
        S_DONE
    } state_t;

    localparam logic [ROW_W-1:0] LAST = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] MAXC = ROW_W'(ROWS);

    state_t           state_q, state_d;
    logic [ROW_W-1:0] rd_row_q, rd_row_d;
    logic [ROW_W-1:0] wr_row_q, wr_row_d;
    logic [ROW_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] fill_rem_q, fill_rem_d;
    logic [ROW_W-1:0] raddr_q, raddr_d;
    logic [ROW_W-1:0] lines_q, lines_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             we;

    always_comb begin
        state_d    = state_q;
        rd_row_d   = rd_row_q;
        wr_row_d   = wr_row_q;
        cnt_d      = cnt_q;
        fill_rem_d = fill_rem_q;
        raddr_d    = raddr_q;
        lines_d    = lines_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        we         = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_row_d = LAST;
                    wr_row_d = LAST;
                    cnt_d    = '0;
                    raddr_d  = LAST;
                    busy_d   = 1'b1;
                    state_d  = S_RD;
                end
            end
            S_RD: begin
                state_d = S_EV;
            end
            S_EV: begin
                if (&mem_rdata) begin
                    if (cnt_q != MAXC) cnt_d = cnt_q + 1'b1;
                end else begin
                    // kept row: always rewritten, even in place
                    we        = 1'b1;
                    mem_waddr = wr_row_q;
                    mem_wdata = mem_rdata;
                    wr_row_d  = wr_row_q - 1'b1;
                end
                if (rd_row_q == '0) begin
                    fill_rem_d = cnt_d;
                    state_d    = S_FILL;
                end else begin
                    rd_row_d = rd_row_q - 1'b1;
                    raddr_d  = rd_row_q - 1'b1;
                    state_d  = S_RD;
                end
            end
            S_FILL: begin
                if (fill_rem_q != '0) begin
                    we         = 1'b1;
                    mem_waddr  = wr_row_q;
                    wr_row_d   = wr_row_q - 1'b1;
                    fill_rem_d = fill_rem_q - 1'b1;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    lines_d = cnt_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            rd_row_q   <= '0;
            wr_row_q   <= '0;
            cnt_q      <= '0;
            fill_rem_q <= '0;
            raddr_q    <= '0;
            lines_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_row_q   <= rd_row_d;
            wr_row_q   <= wr_row_d;
            cnt_q      <= cnt_d;
            fill_rem_q <= fill_rem_d;
            raddr_q    <= raddr_d;
            lines_q    <= lines_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // no RAM write may slip out while reset is held
    assign mem_we        = we & resetn;
    assign busy          = busy_q;
    assign done          = done_q;
    assign lines_cleared = lines_q;
    assign mem_raddr     = raddr_q;

`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] score_q, score_d;
    logic [15:0] bonus;
    logic [16:0] sum;

    always_comb begin
        bonus = 16'd1200;
        if (cnt_q == ROW_W'(0)) bonus = 16'd0;
        else if (cnt_q == ROW_W'(1)) bonus = 16'd40;
        else if (cnt_q == ROW_W'(2)) bonus = 16'd100;
        else if (cnt_q == ROW_W'(3)) bonus = 16'd300;
        sum     = {1'b0, score_q} + {1'b0, bonus};
        score_d = score_q;
        if (state_q == S_DONE) score_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) score_q <= '0;
        else         score_q <= score_d;
    end

    assign score = score_q;
`else
    assign score = 16'd0;
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl: behavioural sync RAM, pass latency,
// write order, compacted board contents, start-while-busy and mid-pass reset.
module tb_line_clear_ctrl;

    localparam int ROWS  = 20;
    localparam int COLS  = 10;
    localparam int ROW_W = 5;

    logic             CLOCK_50 = 1'b0;
    logic             resetn   = 1'b0;
    logic             start    = 1'b0;
    logic             busy;
    logic             done;
    logic [ROW_W-1:0] lines_cleared;
    logic [ROW_W-1:0] mem_raddr;
    logic [COLS-1:0]  mem_rdata;
    logic             mem_we;
    logic [ROW_W-1:0] mem_waddr;
    logic [COLS-1:0]  mem_wdata;
    logic [15:0]      score;

    logic [COLS-1:0]  mem    [0:ROWS-1];
    logic [COLS-1:0]  init_b [0:ROWS-1];
    logic             load_req = 1'b0;
    int               wa_log [0:63];
    int               wd_log [0:63];
    int               wlog_n;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W)) dut (
        .CLOCK_50      (CLOCK_50),
        .resetn        (resetn),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .mem_raddr     (mem_raddr),
        .mem_rdata     (mem_rdata),
        .mem_we        (mem_we),
        .mem_waddr     (mem_waddr),
        .mem_wdata     (mem_wdata),
        .score         (score)
    );

    // synchronous board RAM plus write log
    always @(posedge CLOCK_50) begin
        if (load_req) begin
            for (int r = 0; r < ROWS; r++) mem[r] <= init_b[r];
            wlog_n <= 0;
        end else if (mem_we) begin
            if (int'(mem_waddr) < ROWS) mem[mem_waddr] <= mem_wdata;
            if (wlog_n < 64) begin
                wa_log[wlog_n] <= int'(mem_waddr);
                wd_log[wlog_n] <= int'(mem_wdata);
            end
            wlog_n <= wlog_n + 1;
        end
        mem_rdata <= (int'(mem_raddr) < ROWS) ? mem[mem_raddr] : '0;
    end

    task automatic chk(input string tag, input logic [199:0] obs,
                       input logic [199:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic logic [199:0] board();
        logic [199:0] b;
        b = '0;
        for (int r = 0; r < ROWS; r++) b[r*COLS +: COLS] = mem[r];
        return b;
    endfunction

    task automatic load(input logic [COLS-1:0] r19, input logic [COLS-1:0] r18,
                        input logic [COLS-1:0] r17, input logic [COLS-1:0] r16,
                        input logic [COLS-1:0] r15);
        for (int r = 0; r < ROWS; r++) init_b[r] = '0;
        init_b[19] = r19;
        init_b[18] = r18;
        init_b[17] = r17;
        init_b[16] = r16;
        init_b[15] = r15;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    // returns cycles from start being raised to done seen (-1 on timeout)
    task automatic run_pass(input bit extra, output int lat, output int ndone);
        int cyc;
        lat   = -1;
        ndone = 0;
        cyc   = 0;
        start = 1'b1;
        while (cyc < 300) begin
            tick();
            cyc++;
            start = extra && (cyc == 5 || cyc == 20);
            if (done) begin
                ndone++;
                if (lat < 0) lat = cyc;
            end
            if (lat >= 0 && cyc >= lat + 30) break;
        end
        start = 1'b0;
        if (lat < 0) chk("pass_timeout", 200'd0, 200'd1);
    endtask

    initial begin
        int lat;
        int nd;
        logic [199:0] eb;

        resetn = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_lines", lines_cleared, 0);
        chk("rst_raddr", mem_raddr, 0);
        chk("rst_score", score, 0);
        resetn = 1'b1;
        tick();

        // empty board
        load(10'h000, 10'h000, 10'h000, 10'h000, 10'h000);
        run_pass(1'b0, lat, nd);
        chk("empty_lat", lat, 42);
        chk("empty_ndone", nd, 1);
        chk("empty_lines", lines_cleared, 0);
        chk("empty_nwr", wlog_n, 20);
        for (int i = 0; i < 20; i++) begin
            chk("empty_waddr", wa_log[i], 19 - i);
            chk("empty_wdata", wd_log[i], 0);
        end
        chk("empty_board", board(), 200'd0);
        chk("idle_busy", busy, 0);
        chk("empty_score", score, 0);

        // one full row
        load(10'h3FF, 10'h001, 10'h000, 10'h000, 10'h000);
        run_pass(1'b0, lat, nd);
        eb = '0;
        eb[19*COLS +: COLS] = 10'h001;
        chk("one_lat", lat, 43);
        chk("one_lines", lines_cleared, 1);
        chk("one_board", board(), eb);
`ifdef LINE_CLEAR_SCORE_EN
        chk("score_1", score, 40);
`else
        chk("score_off1", score, 0);
`endif

        // four full rows
        load(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h155);
        run_pass(1'b0, lat, nd);
        eb = '0;
        eb[19*COLS +: COLS] = 10'h155;
        chk("four_lat", lat, 46);
        chk("four_lines", lines_cleared, 4);
        chk("four_board", board(), eb);
        chk("four_nwr", wlog_n, 20);
        chk("four_fill_last", wa_log[19], 0);
`ifdef LINE_CLEAR_SCORE_EN
        chk("score_4", score, 1240);
`endif

        // two interleaved full rows
        load(10'h3FF, 10'h200, 10'h3FF, 10'h00F, 10'h000);
        run_pass(1'b0, lat, nd);
        eb = '0;
        eb[19*COLS +: COLS] = 10'h200;
        eb[18*COLS +: COLS] = 10'h00F;
        chk("two_lat", lat, 44);
        chk("two_lines", lines_cleared, 2);
        chk("two_board", board(), eb);
`ifdef LINE_CLEAR_SCORE_EN
        chk("score_2", score, 1340);
`endif

        // start pulsed again mid-pass must be ignored
        load(10'h3FF, 10'h200, 10'h3FF, 10'h00F, 10'h000);
        run_pass(1'b1, lat, nd);
        chk("restart_lat", lat, 44);
        chk("restart_ndone", nd, 1);
        chk("restart_busy", busy, 0);
        chk("restart_board", board(), eb);

`ifdef LINE_CLEAR_SCORE_EN
        for (int k = 0; k < 55; k++) begin
            load(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h000);
            run_pass(1'b0, lat, nd);
        end
        chk("score_sat", score, 16'hFFFF);
`endif

        // reset mid-pass
        load(10'h3FF, 10'h000, 10'h000, 10'h000, 10'h000);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("mid_busy_pre", busy, 1);
        resetn = 1'b0;
        tick();
        chk("mid_busy", busy, 0);
        chk("mid_we", mem_we, 0);
        chk("mid_lines", lines_cleared, 0);
        chk("mid_score", score, 0);
        resetn = 1'b1;
        repeat (3) tick();
        chk("post_busy", busy, 0);
        chk("post_we", mem_we, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
